// File: rtl/output_port_controller.sv
// rtl/output_port_controller.sv - router output port: grant lock, input pop, one-entry output register
module output_port_controller #(
    parameter int DATA_WIDTH = 34
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [2:0]            rr_priority_to_cs_i,
    input  logic                  grant_valid_i,
    input  logic [DATA_WIDTH-1:0] flit_n_i,
    input  logic [DATA_WIDTH-1:0] flit_s_i,
    input  logic [DATA_WIDTH-1:0] flit_w_i,
    input  logic [DATA_WIDTH-1:0] flit_e_i,
    input  logic [DATA_WIDTH-1:0] flit_l_i,
    input  logic                  valid_n_i,
    input  logic                  valid_s_i,
    input  logic                  valid_w_i,
    input  logic                  valid_e_i,
    input  logic                  valid_l_i,
    output logic                  pop_n_o,
    output logic                  pop_s_o,
    output logic                  pop_w_o,
    output logic                  pop_e_o,
    output logic                  pop_l_o,
    output logic [DATA_WIDTH-1:0] flit_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [4:0]            sel_o,
    output logic                  rr_change_order_o,
    output logic                  busy_o,
    output logic                  proto_err_o
);

    typedef enum logic {S_IDLE, S_ACTIVE} state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [4:0]            r_sel;
    logic [DATA_WIDTH-1:0] r_flit;
    logic                  r_valid;
    logic                  r_rr_change;
    logic                  r_busy;
    logic                  r_proto_err;
    logic                  r_first;

    logic [4:0]            w_grant_sel;
    logic [DATA_WIDTH-1:0] w_grant_flit;
    logic                  w_grant_vld;
    logic                  w_code_ok;
    logic                  w_grant_live;
    logic                  w_accept;
    logic                  w_grant_err;
    logic [DATA_WIDTH-1:0] w_act_flit;
    logic                  w_act_vld;
    logic                  w_xfer;
    logic                  w_act_head;
    logic                  w_act_last;
    logic [4:0]            w_pop;

    // Grant decode used only while IDLE; codes 5-7 fall to the default.
    always_comb begin
        w_grant_sel  = 5'b00000;
        w_grant_flit = '0;
        w_grant_vld  = 1'b0;
        case (rr_priority_to_cs_i)
            3'd0: begin w_grant_sel = 5'b10000; w_grant_flit = flit_n_i; w_grant_vld = valid_n_i; end
            3'd1: begin w_grant_sel = 5'b01000; w_grant_flit = flit_s_i; w_grant_vld = valid_s_i; end
            3'd2: begin w_grant_sel = 5'b00100; w_grant_flit = flit_w_i; w_grant_vld = valid_w_i; end
            3'd3: begin w_grant_sel = 5'b00010; w_grant_flit = flit_e_i; w_grant_vld = valid_e_i; end
            3'd4: begin w_grant_sel = 5'b00001; w_grant_flit = flit_l_i; w_grant_vld = valid_l_i; end
            default: ;
        endcase
    end

    assign w_code_ok    = (rr_priority_to_cs_i <= 3'd4);
    // The arbiter has not yet seen the completion pulse, so its grant is stale.
    assign w_grant_live = (r_state == S_IDLE) && grant_valid_i && !r_rr_change;
    assign w_accept     = w_grant_live && w_code_ok && w_grant_vld && w_grant_flit[DATA_WIDTH-1];
    assign w_grant_err  = w_grant_live && (!w_code_ok || (w_grant_vld && !w_grant_flit[DATA_WIDTH-1]));

    assign w_act_flit = ({DATA_WIDTH{r_sel[4]}} & flit_n_i) |
                        ({DATA_WIDTH{r_sel[3]}} & flit_s_i) |
                        ({DATA_WIDTH{r_sel[2]}} & flit_w_i) |
                        ({DATA_WIDTH{r_sel[1]}} & flit_e_i) |
                        ({DATA_WIDTH{r_sel[0]}} & flit_l_i);
    assign w_act_vld  = |(r_sel & {valid_n_i, valid_s_i, valid_w_i, valid_e_i, valid_l_i});
    assign w_xfer     = (r_state == S_ACTIVE) && w_act_vld && (!r_valid || ready_i);
    assign w_act_head = w_act_flit[DATA_WIDTH-1];
    assign w_act_last = w_act_flit[DATA_WIDTH-2];

    assign w_pop   = (rst || !w_xfer) ? 5'b00000 : r_sel;
    assign pop_n_o = w_pop[4];
    assign pop_s_o = w_pop[3];
    assign pop_w_o = w_pop[2];
    assign pop_e_o = w_pop[1];
    assign pop_l_o = w_pop[0];

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   if (w_accept) w_state_next = S_ACTIVE;
            S_ACTIVE: if (w_xfer && w_act_last) w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sel       <= 5'b00000;
            r_flit      <= '0;
            r_valid     <= 1'b0;
            r_rr_change <= 1'b0;
            r_busy      <= 1'b0;
            r_proto_err <= 1'b0;
            r_first     <= 1'b0;
        end else begin
            r_rr_change <= 1'b0;
            r_busy      <= (w_state_next == S_ACTIVE);
            if (w_accept) begin
                r_sel   <= w_grant_sel;
                r_first <= 1'b1;
            end
            if (w_xfer) begin
                r_flit  <= w_act_flit;
                r_valid <= 1'b1;
                r_first <= 1'b0;
                if (w_act_head && !r_first) r_proto_err <= 1'b1;
                if (w_act_last) begin
                    r_sel       <= 5'b00000;
                    r_rr_change <= 1'b1;
                end
            end else if (ready_i) begin
                r_valid <= 1'b0;
            end
            if (w_grant_err) r_proto_err <= 1'b1;
        end
    end

    assign flit_o            = r_flit;
    assign valid_o           = r_valid;
    assign sel_o             = r_sel;
    assign rr_change_order_o = r_rr_change;
    assign busy_o            = r_busy;
    assign proto_err_o       = r_proto_err;

endmodule

// File: tb/tb_output_port_controller.sv
// tb/tb_output_port_controller.sv - scoreboard bench for output_port_controller
module tb_output_port_controller;
    localparam int DW = 34;

    logic          clk = 1'b0;
    logic          rst;
    logic [2:0]    code;
    logic          gvalid;
    logic [DW-1:0] flit_in [5];
    logic [4:0]    valid_in;
    logic          pop_n, pop_s, pop_w, pop_e, pop_l;
    logic [DW-1:0] flit_o;
    logic          valid_o, ready_i, rr_change, busy, proto_err;
    logic [4:0]    sel_o;

    always #5 clk = ~clk;

    output_port_controller #(.DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst),
        .rr_priority_to_cs_i(code), .grant_valid_i(gvalid),
        .flit_n_i(flit_in[0]), .flit_s_i(flit_in[1]), .flit_w_i(flit_in[2]),
        .flit_e_i(flit_in[3]), .flit_l_i(flit_in[4]),
        .valid_n_i(valid_in[0]), .valid_s_i(valid_in[1]), .valid_w_i(valid_in[2]),
        .valid_e_i(valid_in[3]), .valid_l_i(valid_in[4]),
        .pop_n_o(pop_n), .pop_s_o(pop_s), .pop_w_o(pop_w), .pop_e_o(pop_e), .pop_l_o(pop_l),
        .flit_o(flit_o), .valid_o(valid_o), .ready_i(ready_i), .sel_o(sel_o),
        .rr_change_order_o(rr_change), .busy_o(busy), .proto_err_o(proto_err)
    );

    // Input FIFOs (index 0=N,1=S,2=W,3=E,4=L) and the expected output stream.
    logic [DW-1:0] in_q [5][$];
    logic [DW-1:0] exp_q [$];
    logic [4:0]    exp_sel = 5'b0;
    logic [4:0]    pend_pop = 5'b0;
    logic [15:0]   seq = 16'd0;
    int            ready_mode = 0;
    bit            gap_en = 1'b0;
    int            n_chk = 0;
    int            n_fail = 0;

    int            cyc = 0, rr_cnt, valid_cnt, busy_cnt, first_pop, last_pop, rr_cyc;
    int            pop_cnt [5];
    logic          prev_rst = 1'b1, prev_pop = 1'b0, prev_stall = 1'b0, prev_rr = 1'b0;
    logic [DW-1:0] prev_flit = '0, prev_out = '0;
    logic [4:0]    pop_p, pop_sl;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic refresh();
        for (int p = 0; p < 5; p++) begin
            valid_in[p] = (in_q[p].size() > 0) && !(gap_en && ($urandom_range(0, 3) == 0));
            flit_in[p]  = (in_q[p].size() > 0) ? in_q[p][0] : '0;
        end
        case (ready_mode)
            0:       ready_i = 1'b1;
            1:       ready_i = ($urandom_range(0, 3) != 0);
            default: ready_i = 1'b0;
        endcase
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        for (int p = 0; p < 5; p++)
            if (pend_pop[p] && in_q[p].size() > 0) void'(in_q[p].pop_front());
        pend_pop = 5'b0;
        refresh();
    endtask

    task automatic clear_all();
        for (int p = 0; p < 5; p++) in_q[p].delete();
        exp_q.delete();
        pend_pop = 5'b0;
        refresh();
    endtask

    task automatic clear_stats();
        for (int p = 0; p < 5; p++) pop_cnt[p] = 0;
        rr_cnt = 0; valid_cnt = 0; busy_cnt = 0;
        first_pop = -1; last_pop = -1; rr_cyc = -1;
    endtask

    task automatic mk(input logic [1:0] t, output logic [DW-1:0] f);
        seq++;
        f = {t, seq, 16'($urandom)};
    endtask

    task automatic load_packet(input int p, input int len);
        logic [DW-1:0] f;
        logic [1:0]    t;
        for (int i = 0; i < len; i++) begin
            if (len == 1)           t = 2'b11;
            else if (i == 0)        t = 2'b10;
            else if (i == len - 1)  t = 2'b01;
            else                    t = 2'b00;
            mk(t, f);
            in_q[p].push_back(f);
            exp_q.push_back(f);
        end
        exp_sel = 5'b10000 >> p;
        refresh();
    endtask

    task automatic grant_port(input int p);
        int n = 0;
        gvalid = 1'b1;
        code   = 3'(p);
        while (!busy && n < 200) begin
            tick();
            n++;
        end
        gvalid = 1'b0;
        chk("grant_taken", busy, 1);
    endtask

    task automatic wait_done(input bit churn);
        int n = 0;
        bit seen = 0;
        while (!seen && n < 400) begin
            if (churn) begin
                gvalid = 1'b1;
                code   = 3'($urandom_range(0, 7));
            end
            tick();
            n++;
            if (rr_change) seen = 1;
        end
        gvalid = 1'b0;
        chk("packet_done", seen, 1);
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        clear_all();
        tick();
        rst = 1'b0;
        chk("rst_state", {busy, valid_o, sel_o, rr_change, proto_err}, 0);
        chk("rst_flit", flit_o, 0);
    endtask

    // Monitor: protocol rules every cycle, scoreboard on every downstream accept.
    always @(negedge clk) begin
        pop_p  = {pop_l, pop_e, pop_w, pop_s, pop_n};
        pop_sl = {pop_n, pop_s, pop_w, pop_e, pop_l};
        cyc++;
        if (rst) begin
            chk("pop_in_reset", pop_p, 0);
        end else begin
            chk("pop_onehot", ($countones(pop_p) <= 1), 1);
            chk("pop_only_sel", pop_sl & ~sel_o, 0);
            if (valid_o && !ready_i) chk("pop_in_stall", pop_p, 0);
            if (!prev_rst) begin
                if (prev_pop) begin
                    chk("pop_to_valid", valid_o, 1);
                    chk("pop_to_flit", flit_o, prev_flit);
                    chk("rr_after_pop", rr_change, prev_flit[DW-2]);
                    if (prev_flit[DW-2]) chk("idle_after_tail", {busy, sel_o}, 0);
                end else begin
                    chk("rr_without_pop", rr_change, 0);
                end
                if (prev_stall) chk("stall_hold", {valid_o, flit_o}, {1'b1, prev_out});
                if (prev_rr) chk("no_grant_in_rr", busy, 0);
            end
            if (busy) chk("sel_locked", sel_o, exp_sel);
            if (valid_o && ready_i) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL sb_unexpected: got %0h expected nothing", flit_o);
                end else begin
                    chk("sb_flit", flit_o, exp_q.pop_front());
                end
            end
            for (int p = 0; p < 5; p++) begin
                if (pop_p[p]) begin
                    pop_cnt[p]++;
                    if (first_pop < 0) first_pop = cyc;
                    last_pop    = cyc;
                    pend_pop[p] = 1'b1;
                end
            end
            if (rr_change) begin rr_cnt++; rr_cyc = cyc; end
            if (valid_o) valid_cnt++;
            if (busy) busy_cnt++;
        end
        prev_rst   = rst;
        prev_pop   = !rst && (|pop_p);
        prev_flit  = '0;
        for (int p = 0; p < 5; p++) if (pop_p[p]) prev_flit = flit_in[p];
        prev_stall = !rst && valid_o && !ready_i;
        prev_out   = flit_o;
        prev_rr    = !rst && rr_change;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int p0;
        logic [DW-1:0] f;
        rst = 1'b1; gvalid = 1'b0; code = 3'd0; ready_i = 1'b1;
        valid_in = 5'b0;
        for (int p = 0; p < 5; p++) flit_in[p] = '0;
        clear_stats();
        tick();
        tick();
        rst = 1'b0;
        chk("reset_state", {busy, valid_o, sel_o, rr_change, proto_err}, 0);
        chk("reset_flit", flit_o, 0);

        // 3-flit packet on S at full throughput
        clear_stats();
        load_packet(1, 3);
        grant_port(1);
        chk("s_sel", sel_o, 5'b01000);
        wait_done(0);
        repeat (2) tick();
        chk("s_pops", pop_cnt[1], 3);
        chk("s_pop_span", last_pop - first_pop, 2);
        chk("s_other_pops", pop_cnt[0] + pop_cnt[2] + pop_cnt[3] + pop_cnt[4], 0);
        chk("s_valid_cycles", valid_cnt, 3);
        chk("s_rr_pulses", rr_cnt, 1);

        // single-flit packet on L
        clear_stats();
        load_packet(4, 1);
        grant_port(4);
        wait_done(0);
        repeat (2) tick();
        chk("l_busy_cycles", busy_cnt, 1);
        chk("l_pops", pop_cnt[4], 1);
        chk("l_valid_cycles", valid_cnt, 1);
        chk("l_rr_delay", rr_cyc - last_pop, 1);

        // grant held across completion: second packet waits one extra cycle
        clear_stats();
        load_packet(4, 1);
        load_packet(4, 1);
        gvalid = 1'b1; code = 3'd4;
        p0 = 0;
        while (rr_cnt < 2 && p0 < 100) begin tick(); p0++; end
        gvalid = 1'b0;
        repeat (2) tick();
        chk("held_rr_pulses", rr_cnt, 2);
        chk("held_busy_cycles", busy_cnt, 2);

        // 4-cycle downstream stall mid-packet on E
        clear_stats();
        load_packet(3, 5);
        grant_port(3);
        p0 = 0;
        while (in_q[3].size() > 3 && p0 < 50) begin tick(); p0++; end
        ready_mode = 2; ready_i = 1'b0;
        p0 = pop_cnt[3];
        repeat (4) tick();
        chk("stall_no_pops", pop_cnt[3], p0);
        ready_mode = 0; ready_i = 1'b1;
        #1;
        chk("stall_resume_pop", pop_e, 1);
        wait_done(0);
        repeat (2) tick();
        chk("e_pops", pop_cnt[3], 5);
        chk("e_sb_drained", exp_q.size(), 0);

        // invalid grant code
        clear_stats();
        gvalid = 1'b1; code = 3'd6;
        tick();
        gvalid = 1'b0;
        repeat (3) tick();
        chk("bad_code_err", proto_err, 1);
        chk("bad_code_busy", busy_cnt, 0);
        reset_dut();

        // grant to empty port: ignored silently
        gvalid = 1'b1; code = 3'd1;
        tick();
        gvalid = 1'b0;
        repeat (2) tick();
        chk("empty_grant_err", proto_err, 0);
        chk("empty_grant_busy", busy, 0);

        // grant to W whose head-of-FIFO is a body flit
        clear_stats();
        mk(2'b00, f);
        in_q[2].push_back(f);
        refresh();
        gvalid = 1'b1; code = 3'd2;
        tick();
        gvalid = 1'b0;
        repeat (3) tick();
        chk("body_grant_err", proto_err, 1);
        chk("body_grant_pops", pop_cnt[2], 0);
        chk("body_grant_busy", busy_cnt, 0);
        reset_dut();

        // reset on the body flit of an N packet, then a clean packet
        clear_stats();
        load_packet(0, 4);
        grant_port(0);
        p0 = 0;
        while (in_q[0].size() > 3 && p0 < 50) begin tick(); p0++; end
        rst = 1'b1;
        clear_all();
        tick();
        rst = 1'b0;
        chk("midrst_state", {busy, valid_o, sel_o, rr_change}, 0);
        tick();
        chk("midrst_no_rr", rr_cnt, 0);
        load_packet(0, 3);
        grant_port(0);
        wait_done(0);
        repeat (2) tick();
        chk("midrst_after_drained", exp_q.size(), 0);

        // grant churns while N packet is active
        clear_stats();
        load_packet(0, 4);
        grant_port(0);
        wait_done(1);
        repeat (2) tick();
        chk("churn_n_pops", pop_cnt[0], 4);
        chk("churn_other_pops", pop_cnt[1] + pop_cnt[2] + pop_cnt[3] + pop_cnt[4], 0);
        chk("churn_no_err", proto_err, 0);

        // randomized packets with downstream backpressure and input gaps
        ready_mode = 1;
        gap_en = 1'b1;
        for (int k = 0; k < 30; k++) begin
            p0 = $urandom_range(0, 4);
            load_packet(p0, $urandom_range(1, 5));
            grant_port(p0);
            wait_done(0);
        end
        ready_mode = 0;
        gap_en = 1'b0;
        refresh();
        repeat (3) tick();
        chk("rand_sb_drained", exp_q.size(), 0);
        chk("rand_no_err", proto_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/output_port_controller.md
OUTPUT_PORT_CONTROLLER -- requirements
Module: output_port_controller

Interface
REQ-001 The module SHALL have parameter DATA_WIDTH, default 34, the flit width; flit[DATA_WIDTH-1:DATA_WIDTH-2] is the type field (2'b10 head, 2'b00 body, 2'b01 tail, 2'b11 single-flit head+tail).
REQ-002 The module SHALL have one clock and a synchronous active-high reset; all ports are listed below, clock and reset first.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 rr_priority_to_cs_i  input  3  encoded grant: 0=N, 1=S, 2=W, 3=E, 4=L; 5-7 invalid.
REQ-006 grant_valid_i  input  1  rr_priority_to_cs_i is meaningful this cycle.
REQ-007 flit_n_i, flit_s_i, flit_w_i, flit_e_i, flit_l_i  input  DATA_WIDTH each  head-of-FIFO flit per input port.
REQ-008 valid_n_i .. valid_l_i  input  1 each  corresponding input FIFO non-empty.
REQ-009 pop_n_o .. pop_l_o  output  1 each  dequeue strobe to the corresponding input FIFO.
REQ-010 flit_o  output  DATA_WIDTH  registered outgoing flit.
REQ-011 valid_o  output  1  flit_o holds a valid flit.
REQ-012 ready_i  input  1  downstream accepts flit_o this cycle.
REQ-013 sel_o  output  5  one-hot locked input select {N,S,W,E,L} as bits [4:0]; all zero when idle.
REQ-014 rr_change_order_o  output  1  one-cycle pulse to the arbiter on packet completion.
REQ-015 busy_o  output  1  high while in ACTIVE.
REQ-016 proto_err_o  output  1  sticky protocol-error flag.

Function
REQ-017 The module SHALL implement two states, IDLE and ACTIVE, plus a one-entry output register (flit_o/valid_o).
REQ-018 In IDLE, when grant_valid_i=1, code is 0-4, the selected valid is 1, and the selected flit type is head or head+tail, the module SHALL latch sel_o to the one-hot decode and enter ACTIVE next cycle; no pop occurs in IDLE.
REQ-019 In IDLE, a grant with code 5-7 SHALL be ignored and SHALL set proto_err_o.
REQ-020 In IDLE, a valid grant whose selected flit is body or tail SHALL be ignored, SHALL set proto_err_o, and SHALL issue no pop.
REQ-021 In IDLE, a grant whose selected valid is 0 SHALL be ignored without an error.
REQ-022 In ACTIVE, the module SHALL ignore grant_valid_i and rr_priority_to_cs_i.
REQ-023 Transfer condition in ACTIVE: selected valid=1 AND (valid_o=0 OR ready_i=1).
REQ-024 On transfer, the module SHALL assert exactly one pop for that cycle and load the selected flit into flit_o with valid_o=1 at the next edge; latency from pop to flit_o is 1 cycle.
REQ-025 When ready_i=1 and valid_o=1 with no transfer, valid_o SHALL clear at the next edge.
REQ-026 Simultaneous downstream accept and new transfer SHALL overwrite flit_o with no bubble, giving one flit per cycle at full throughput.
REQ-027 Stall rule: while valid_o=1 and ready_i=0, flit_o and valid_o SHALL hold and no pop SHALL issue.
REQ-028 When a transferred flit is tail or head+tail, the module SHALL return to IDLE, clear sel_o, and pulse rr_change_order_o for exactly one cycle, all at the next edge.
REQ-029 A new grant SHALL NOT be accepted in the cycle in which rr_change_order_o is high.
REQ-030 A head flit transferred in ACTIVE after the first flit SHALL be forwarded unchanged and SHALL set proto_err_o.
REQ-031 Pop outputs SHALL be combinational from state, sel_o, valid inputs, valid_o and ready_i; every other output SHALL be registered.
REQ-032 At most one pop SHALL be asserted in any cycle, and never for a non-selected port.

Reset
REQ-033 While rst=1 at a clock edge, the module SHALL enter IDLE and set sel_o=0, valid_o=0, flit_o=0, rr_change_order_o=0, busy_o=0 and proto_err_o=0.
REQ-034 Pops SHALL be 0 while rst is high.
REQ-035 Reset asserted mid-packet SHALL abandon the packet and issue no completion pulse.
REQ-036 proto_err_o SHALL clear only on reset.

Verification
REQ-037 Grant 3'b001 with valid_s_i=1, 3-flit S packet (head, body, tail) and ready_i=1 -> sel_o=5'b01000; pop_s_o high for 3 consecutive cycles; flit_o valid 3 consecutive cycles, each one cycle after its pop; rr_change_order_o pulses once; then IDLE.
REQ-038 Grant 3'b100 with L head+tail flit -> one pop_l_o, one valid_o cycle, rr_change_order_o one cycle after the pop, busy_o high exactly 1 cycle.
REQ-039 ready_i held 0 for 4 cycles mid-packet on E -> flit_o stable, no pops during the stall, transfer resumes on the cycle ready_i returns to 1, no flit lost or duplicated.
REQ-040 Grant code 3'b110, or grant to W whose flit is body -> no pop, state stays IDLE, proto_err_o=1 until rst.
REQ-041 rst asserted on the body flit of an N packet -> next cycle IDLE, valid_o=0, sel_o=0, no rr_change_order_o pulse; a fresh grant then proceeds normally.
REQ-042 Grant changes value while ACTIVE on N -> sel_o stays 5'b10000 and only pop_n_o ever asserts until tail.
